dbg_cmd_bridge: RTL and testbench
=================================

# dbg_cmd_bridge

Byte-stream front end for the core debug module. It receives fixed-length command packets from a byte source (UART receiver or JTAG shift register) over valid/ready and drives one `dbg_intf` transaction per packet. It waits for the debug module's `dut_done`, captures the returned word, and streams a 5-byte response back to the byte sink. It sits directly upstream of the core debug module and is the only master of its `dbg_bus`.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum cycles in EXEC before the transaction is aborted; must be ≥2.
- `clk`  in  1  clock
- `rstn_i`  in  1  reset, asynchronous, active-low
- `dbg_bus`  `dbg_intf` master modport  —  drives `cmd[7:0]`, `addr[31:0]`, `data_dbg_dut[31:0]`; samples `dut_done`, `data_dut_dbg[31:0]`
- `rx_data_i`  in  8  incoming packet byte
- `rx_valid_i`  in  1  `rx_data_i` valid
- `rx_ready_o`  out  1  bridge accepts a byte (beat = valid & ready)
- `tx_data_o`  out  8  response byte
- `tx_valid_o`  out  1  `tx_data_o` valid
- `tx_ready_i`  in  1  sink accepts response byte

## Operation
- Request packet is 9 bytes: the cmd byte, then addr as 4 bytes little-endian, then data as 4 bytes little-endian. All fields are always sent, including for commands that ignore them.
- Response packet is 5 bytes: the status byte, then the result as 4 bytes little-endian.
  - Status 0x00: OK.
  - Status 0xE1: illegal command. Result is 0.
  - Status 0xEE: timeout. Result is 0.
- Legal commands are 0x01–0x06. Commands 0x03 and 0x05 return `data_dut_dbg`; all others return the captured value, which is don't-care but must be deterministic (the captured bus value).
- cmd 0x00 is a no-op. The response is 0x00 with result 0, and no bus activity occurs.
- cmd ≥0x07 gets response 0xE1. No bus activity occurs.
- State machine:
  - **RX_CMD**: on a beat, go to RX_ADDR.
  - **RX_ADDR**: on the 4th beat, go to RX_DATA.
  - **RX_DATA**: on the 4th beat, go to EXEC if the command is legal, otherwise TX.
  - **EXEC**: on `dut_done`, capture and go to RELEASE. On timeout, go to RELEASE with status 0xEE.
  - **RELEASE**: go to TX once `dut_done`=0.
  - **TX**: after the 5th accepted byte, go to RX_CMD.
- A 2-bit byte counter is shared by RX_ADDR, RX_DATA and TX. TX uses values 0..4 through a 3-bit index, or the status byte is handled separately.
- `rx_ready_o`=1 exactly in the RX_* states. `tx_valid_o`=1 exactly in TX.
- `dbg_bus.cmd` equals the latched cmd only in EXEC; it is 0x00 in every other state.
- `addr` and `data_dbg_dut` hold the latched values from the end of RX_DATA until they are overwritten by the next packet.
- RELEASE is mandatory. The debug module registers its done flag and holds it for at least one cycle after `cmd` drops, so a stale `dut_done` must never complete the next command.
- Timeout counter:
  - Clears on entry to EXEC and increments each EXEC cycle without `dut_done`.
  - When it reaches `TIMEOUT_CYCLES`-1 without done, cmd drops and status is 0xEE.
  - A `dut_done` in that same cycle wins, giving status 0x00.

## Timing
- Reset values:
  - State RX_CMD.
  - `rx_ready_o`=1. Sources must not push while reset is asserted.
  - `tx_valid_o`=0, `tx_data_o`=0.
  - `cmd`=0, `addr`=0, `data_dbg_dut`=0.
  - Counters and the capture/status registers are 0.
- All state and bus outputs are registered. `rx_ready_o`, `tx_valid_o` and `tx_data_o` are decoded from registered state only, with no combinational path from inputs.
- If the last request beat is at cycle t, `cmd` is valid at t+1.
- If `dut_done` is first seen high at cycle e, then:
  - `data_dut_dbg` is captured in cycle e, with cmd still driven.
  - `cmd`=0 from e+1.
  - The earliest `tx_valid_o` is e+2, which requires `dut_done` to be low at e+1.
- Illegal cmd or cmd 0x00: `tx_valid_o` at t+1.
- TX holds `tx_data_o` stable while `tx_valid_o` & !`tx_ready_i`. One byte advances per accepted cycle.
- After the final TX beat at cycle f, `rx_ready_o`=1 at f+1.
- Bytes arriving while not in an RX_* state are not accepted, because ready is low.
- Reset mid-packet or mid-EXEC returns the block to reset values immediately. A partial packet is discarded.

## Structure
- `dbg_bridge_pkg` holds:
  - the state enum;
  - status constants `DBG_ST_OK`, `DBG_ST_ILLEGAL`, `DBG_ST_TIMEOUT`;
  - command constants `DBG_CMD_NOP` … `DBG_CMD_WRITE_PC` (0x00–0x06), shared with the core debug module;
  - request and response lengths of 9 and 5.
- Single module with no sub-module. The timeout counter is inline, `$clog2(TIMEOUT_CYCLES)` wide.

## Test plan
- Packet 01 00000000 00000000 with a stub asserting registered done one cycle after cmd, held for 2 cycles → `cmd`=0x01 for exactly 2 cycles; response 00 00 00 00 00; no second command issued.
- Packet 03 05000000 00000000 with stub `data_dut_dbg`=0xDEADBEEF → addr=0x5; response 00 EF BE AD DE.
- Packet 04 1F000000 78563412 → addr=0x1F, `data_dbg_dut`=0x12345678 while cmd=0x04; status 00.
- Packet 09… → `cmd` stays 0; response E1 00 00 00 00 on the cycle after the last rx beat.
- Stub never asserts done, with `TIMEOUT_CYCLES`=16 → cmd=0x06 for exactly 16 cycles, then 0; response EE 00 00 00 00.
- `tx_ready_i` toggled 0/1 every cycle during a response, and `rstn_i` pulsed during a later EXEC → bytes held stable and in order; after reset, cmd=0 and the next packet is handled correctly.

Source files
------------

// File: rtl/dbg_cmd_bridge_pkg.sv
// Shared types and constants for the debug command bridge and the core debug module.
// Pure definitions: no logic, no latency, no flow control.
package dbg_bridge_pkg;

  typedef enum logic [2:0] {
    ST_RX_CMD  = 3'd0,
    ST_RX_ADDR = 3'd1,
    ST_RX_DATA = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_TX      = 3'd5
  } dbg_state_e;

  localparam logic [7:0] DBG_ST_OK      = 8'h00;
  localparam logic [7:0] DBG_ST_ILLEGAL = 8'hE1;
  localparam logic [7:0] DBG_ST_TIMEOUT = 8'hEE;

  localparam logic [7:0] DBG_CMD_NOP       = 8'h00;
  localparam logic [7:0] DBG_CMD_HALT      = 8'h01;
  localparam logic [7:0] DBG_CMD_RESUME    = 8'h02;
  localparam logic [7:0] DBG_CMD_READ_REG  = 8'h03;
  localparam logic [7:0] DBG_CMD_WRITE_REG = 8'h04;
  localparam logic [7:0] DBG_CMD_READ_MEM  = 8'h05;
  localparam logic [7:0] DBG_CMD_WRITE_PC  = 8'h06;

  localparam int DBG_REQ_LEN = 9;
  localparam int DBG_RSP_LEN = 5;

  // Commands that actually drive a bus transaction (NOP is answered locally).
  function automatic logic dbg_cmd_is_legal(input logic [7:0] c);
    return (c >= DBG_CMD_HALT) && (c <= DBG_CMD_WRITE_PC);
  endfunction

endpackage

// File: rtl/dbg_cmd_bridge_if.sv
// Bridge-to-debug-module bus: the bridge drives a command, the module answers with done + word.
// Combinational bundle only; completion is signalled by dut_done, no other backpressure.
interface dbg_intf;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [31:0] data_dbg_dut;
  logic        dut_done;
  logic [31:0] data_dut_dbg;

  modport master (
    output cmd, addr, data_dbg_dut,
    input  dut_done, data_dut_dbg
  );

  modport slave (
    input  cmd, addr, data_dbg_dut,
    output dut_done, data_dut_dbg
  );
endinterface

// File: rtl/dbg_cmd_bridge.sv
// Byte stream -> one dbg_bus transaction -> 5-byte response; cmd is driven 1 cycle after the last rx beat.
// rx ready / tx valid are decoded from state only; tx byte is held while the sink stalls.
module dbg_cmd_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rstn_i,
  dbg_intf.master    dbg_bus,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  dbg_state_e    r_state, w_state_nxt;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic          r_tx_body, w_tx_body_nxt;
  logic [7:0]    r_cmd;
  logic [31:0]   r_addr_sh;
  logic [23:0]   r_data_sh;
  logic [7:0]    r_bus_cmd;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_data;
  logic [31:0]   r_result;
  logic [7:0]    r_status;
  logic [TW-1:0] r_tmo;

  logic       w_rx_beat;
  logic       w_tx_beat;
  logic       w_last_byte;
  logic       w_tmo_hit;
  logic [7:0] w_tx_dat;

  assign rx_ready_o  = (r_state == ST_RX_CMD) || (r_state == ST_RX_ADDR) ||
                       (r_state == ST_RX_DATA);
  assign tx_valid_o  = (r_state == ST_TX);
  assign w_rx_beat   = rx_valid_i & rx_ready_o;
  assign w_tx_beat   = tx_valid_o & tx_ready_i;
  assign w_last_byte = (r_cnt == 2'd3);
  assign w_tmo_hit   = (r_tmo == TMO_LAST);

  assign dbg_bus.cmd          = r_bus_cmd;
  assign dbg_bus.addr         = r_bus_addr;
  assign dbg_bus.data_dbg_dut = r_bus_data;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_RX_CMD;
      r_cnt     <= 2'd0;
      r_tx_body <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tx_body <= w_tx_body_nxt;
    end
  end

  // The 2-bit counter wraps to 0 after each 4-byte field, so TX always starts at 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tx_body_nxt = r_tx_body;
    case (r_state)
      ST_RX_CMD: begin
        if (w_rx_beat) begin
          w_state_nxt = ST_RX_ADDR;
          w_cnt_nxt   = 2'd0;
        end
      end
      ST_RX_ADDR: begin
        if (w_rx_beat) begin
          w_cnt_nxt = r_cnt + 2'd1;
          if (w_last_byte) w_state_nxt = ST_RX_DATA;
        end
      end
      ST_RX_DATA: begin
        if (w_rx_beat) begin
          w_cnt_nxt     = r_cnt + 2'd1;
          w_tx_body_nxt = 1'b0;
          if (w_last_byte) w_state_nxt = dbg_cmd_is_legal(r_cmd) ? ST_EXEC : ST_TX;
        end
      end
      ST_EXEC: begin
        if (dbg_bus.dut_done || w_tmo_hit) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_tx_body_nxt = 1'b0;
        if (!dbg_bus.dut_done) w_state_nxt = ST_TX;
      end
      ST_TX: begin
        if (w_tx_beat) begin
          if (!r_tx_body) begin
            w_tx_body_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
            if (w_last_byte) begin
              w_state_nxt   = ST_RX_CMD;
              w_tx_body_nxt = 1'b0;
            end
          end
        end
      end
      default: begin
        w_state_nxt   = ST_RX_CMD;
        w_cnt_nxt     = 2'd0;
        w_tx_body_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cmd      <= 8'h00;
      r_addr_sh  <= 32'h0;
      r_data_sh  <= 24'h0;
      r_bus_cmd  <= 8'h00;
      r_bus_addr <= 32'h0;
      r_bus_data <= 32'h0;
      r_result   <= 32'h0;
      r_status   <= 8'h00;
      r_tmo      <= '0;
    end else begin
      case (r_state)
        ST_RX_CMD: begin
          if (w_rx_beat) r_cmd <= rx_data_i;
        end
        ST_RX_ADDR: begin
          if (w_rx_beat) r_addr_sh <= {rx_data_i, r_addr_sh[31:8]};
        end
        ST_RX_DATA: begin
          if (w_rx_beat) begin
            r_data_sh <= {rx_data_i, r_data_sh[23:8]};
            if (w_last_byte) begin
              r_bus_addr <= r_addr_sh;
              r_bus_data <= {rx_data_i, r_data_sh};
              r_result   <= 32'h0;
              r_tmo      <= '0;
              if (dbg_cmd_is_legal(r_cmd)) begin
                r_bus_cmd <= r_cmd;
                r_status  <= DBG_ST_OK;
              end else begin
                r_status  <= (r_cmd == DBG_CMD_NOP) ? DBG_ST_OK : DBG_ST_ILLEGAL;
              end
            end
          end
        end
        ST_EXEC: begin
          // done in the final counted cycle still completes normally
          if (dbg_bus.dut_done) begin
            r_result  <= dbg_bus.data_dut_dbg;
            r_bus_cmd <= 8'h00;
          end else if (w_tmo_hit) begin
            r_bus_cmd <= 8'h00;
            r_status  <= DBG_ST_TIMEOUT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_tx_dat = 8'h00;
    if (r_state == ST_TX) begin
      if (!r_tx_body) begin
        w_tx_dat = r_status;
      end else begin
        case (r_cnt)
          2'd0:    w_tx_dat = r_result[7:0];
          2'd1:    w_tx_dat = r_result[15:8];
          2'd2:    w_tx_dat = r_result[23:16];
          default: w_tx_dat = r_result[31:24];
        endcase
      end
    end
  end

  assign tx_data_o = w_tx_dat;

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// Bench for dbg_cmd_bridge: debug-module stub with programmable done delay/hold, byte source/sink,
// and a packet-level reference model for responses, bus activity and response latency.
module tb_dbg_cmd_bridge;
  import dbg_bridge_pkg::*;

  localparam int TMO = 16;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  always #5 clk = ~clk;

  dbg_intf bus ();

  dbg_cmd_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rstn_i     (rstn),
    .dbg_bus    (bus.master),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready)
  );

  // debug-module stub: registered done, first high 'delay' cycles after cmd rises, held 'hold' cycles
  int          stub_delay = 1;
  int          stub_hold  = 2;
  bit          stub_never = 1'b0;
  logic [31:0] stub_rdata = 32'h0;
  logic        stub_done;
  logic [7:0]  stub_prev;
  int          stub_tmr, stub_hcnt;

  assign bus.dut_done     = stub_done;
  assign bus.data_dut_dbg = stub_rdata;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stub_done <= 1'b0; stub_prev <= 8'h00; stub_tmr <= 0; stub_hcnt <= 0;
    end else begin
      stub_prev <= bus.cmd;
      if (stub_done) begin
        if (stub_hcnt <= 1) stub_done <= 1'b0;
        else stub_hcnt <= stub_hcnt - 1;
      end else if (stub_tmr > 0) begin
        stub_tmr <= stub_tmr - 1;
        if (stub_tmr == 1) begin stub_done <= 1'b1; stub_hcnt <= stub_hold; end
      end else if (bus.cmd != 8'h00 && stub_prev == 8'h00 && !stub_never) begin
        if (stub_delay <= 1) begin stub_done <= 1'b1; stub_hcnt <= stub_hold; end
        else stub_tmr <= stub_delay - 1;
      end
    end
  end

  // bus monitor: cumulative command cycles / issues and the values seen while cmd is driven
  int          mon_cyc = 0, mon_iss = 0;
  logic [7:0]  mon_prev = 8'h00, mon_cmd = 8'h00;
  logic [31:0] mon_addr = 32'h0, mon_data = 32'h0;

  always @(posedge clk) begin
    mon_prev <= bus.cmd;
    if (bus.cmd != 8'h00) begin
      mon_cyc <= mon_cyc + 1; mon_cmd <= bus.cmd;
      mon_addr <= bus.addr; mon_data <= bus.data_dbg_dut;
    end
    if (bus.cmd != 8'h00 && mon_prev == 8'h00) mon_iss <= mon_iss + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  int chk = 0, pass = 0;

  logic [7:0]  o_resp [5];
  int          o_cyc, o_iss, o_lat;
  bit          o_stable, o_tmo_err;
  logic [7:0]  o_cmd_t1;
  logic [31:0] o_addr_end, o_data_end;
  logic        o_rdy_after, o_vld_after;

  logic [39:0] e_resp;
  int          e_cyc, e_iss, e_lat;

  function automatic logic [39:0] got_resp();
    return {o_resp[0], o_resp[1], o_resp[2], o_resp[3], o_resp[4]};
  endfunction

  // reference: packet-level outcome from command, stub answer and stub timing
  task automatic model(input logic [7:0] c, input logic [31:0] rd, input int dly, input int hld,
                       input bit never, output logic [39:0] resp, output int cyc,
                       output int iss, output int lat);
    logic [7:0]  st;
    logic [31:0] res;
    if (c == 8'h00) begin
      st = 8'h00; res = 32'h0; cyc = 0; iss = 0; lat = 1;
    end else if (c > 8'h06) begin
      st = 8'hE1; res = 32'h0; cyc = 0; iss = 0; lat = 1;
    end else if (never || dly + 1 > TMO) begin
      st = 8'hEE; res = 32'h0; cyc = TMO; iss = 1; lat = TMO + 2;
    end else begin
      st = 8'h00; res = rd; cyc = dly + 1; iss = 1; lat = dly + hld + 2;
    end
    resp = {st, res[7:0], res[15:8], res[23:16], res[31:24]};
  endtask

  task automatic set_stub(input int dly, input int hld, input bit never, input logic [31:0] rd);
    stub_delay = dly; stub_hold = hld; stub_never = never; stub_rdata = rd;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    if ($urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin @(negedge clk); n++; end
    if (!rx_ready) o_tmo_err = 1'b1;
    @(posedge clk);
  endtask

  // mode 0: sink always ready, 1: ready toggles every cycle, 2: random ready
  task automatic do_txn(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                        input int mode);
    int         cyc0, iss0, n, acc;
    bit         hold_prev;
    logic [7:0] dat_prev;
    logic [7:0] req [9];
    req[0] = c;
    for (int i = 0; i < 4; i++) begin
      req[1+i] = a[8*i +: 8];
      req[5+i] = d[8*i +: 8];
    end
    cyc0 = mon_cyc; iss0 = mon_iss;
    o_tmo_err = 1'b0; o_stable = 1'b1; o_lat = 0;
    for (int i = 0; i < DBG_RSP_LEN; i++) o_resp[i] = 8'hxx;
    for (int i = 0; i < DBG_REQ_LEN; i++) send_byte(req[i]);
    @(negedge clk);
    rx_valid   = 1'b0;
    o_cmd_t1   = bus.cmd;
    o_addr_end = bus.addr;
    o_data_end = bus.data_dbg_dut;
    n = 1; acc = 0; hold_prev = 1'b0; dat_prev = 8'h00;
    while (acc < DBG_RSP_LEN && n < 400) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = n[0];
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tx_valid) begin
        if (o_lat == 0) o_lat = n;
        if (hold_prev && tx_data !== dat_prev) o_stable = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        o_resp[acc] = tx_data; acc++; hold_prev = 1'b0;
      end else begin
        hold_prev = tx_valid; dat_prev = tx_data;
      end
      if (acc < DBG_RSP_LEN) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    tx_ready    = 1'b0;
    o_rdy_after = rx_ready;
    o_vld_after = tx_valid;
    o_cyc = mon_cyc - cyc0;
    o_iss = mon_iss - iss0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b exp 1", rx_ready); else pass++;
    chk++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); else pass++;
    chk++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h exp 00", tx_data); else pass++;
    chk++; if (bus.cmd !== 8'h00) $display("FAIL reset_cmd: got %h exp 00", bus.cmd); else pass++;
    chk++; if (bus.addr !== 32'h0) $display("FAIL reset_addr: got %h exp 0", bus.addr); else pass++;
    chk++; if (bus.data_dbg_dut !== 32'h0) $display("FAIL reset_data: got %h exp 0", bus.data_dbg_dut); else pass++;
    rstn = 1'b1;
  endtask

  task automatic test_halt();
    set_stub(1, 2, 1'b0, 32'h0);
    model(8'h01, 32'h0, 1, 2, 1'b0, e_resp, e_cyc, e_iss, e_lat);
    do_txn(8'h01, 32'h0, 32'h0, 0);
    chk++; if (got_resp() !== e_resp) $display("FAIL halt_resp: got %h exp %h", got_resp(), e_resp); else pass++;
    chk++; if (o_cyc !== e_cyc) $display("FAIL halt_cmd_cycles: got %0d exp %0d", o_cyc, e_cyc); else pass++;
    chk++; if (o_iss !== e_iss) $display("FAIL halt_issues: got %0d exp %0d", o_iss, e_iss); else pass++;
    chk++; if (o_lat !== e_lat) $display("FAIL halt_tx_latency: got %0d exp %0d", o_lat, e_lat); else pass++;
    chk++; if (o_cmd_t1 !== 8'h01) $display("FAIL halt_cmd_at_t1: got %h exp 01", o_cmd_t1); else pass++;
    chk++; if ({o_rdy_after, o_vld_after} !== 2'b10)
      $display("FAIL halt_ready_after_tx: got rdy=%b vld=%b exp rdy=1 vld=0", o_rdy_after, o_vld_after); else pass++;
  endtask

  task automatic test_read();
    set_stub(1, 2, 1'b0, 32'hDEADBEEF);
    model(8'h03, 32'hDEADBEEF, 1, 2, 1'b0, e_resp, e_cyc, e_iss, e_lat);
    do_txn(8'h03, 32'h5, 32'h0, 0);
    chk++; if (mon_addr !== 32'h5) $display("FAIL read_addr: got %h exp 00000005", mon_addr); else pass++;
    chk++; if (got_resp() !== e_resp) $display("FAIL read_resp: got %h exp %h", got_resp(), e_resp); else pass++;
    chk++; if (o_lat !== e_lat) $display("FAIL read_tx_latency: got %0d exp %0d", o_lat, e_lat); else pass++;
  endtask

  task automatic test_write();
    set_stub(3, 1, 1'b0, 32'h0BADF00D);
    model(8'h04, 32'h0BADF00D, 3, 1, 1'b0, e_resp, e_cyc, e_iss, e_lat);
    do_txn(8'h04, 32'h1F, 32'h12345678, 2);
    chk++; if (mon_cmd !== 8'h04) $display("FAIL write_cmd: got %h exp 04", mon_cmd); else pass++;
    chk++; if (mon_addr !== 32'h1F) $display("FAIL write_addr: got %h exp 0000001f", mon_addr); else pass++;
    chk++; if (mon_data !== 32'h12345678) $display("FAIL write_data: got %h exp 12345678", mon_data); else pass++;
    chk++; if (got_resp() !== e_resp) $display("FAIL write_resp: got %h exp %h", got_resp(), e_resp); else pass++;
  endtask

  task automatic test_illegal_nop();
    logic [31:0] a, d;
    a = $urandom; d = $urandom;
    model(8'h09, 32'h0, 1, 1, 1'b0, e_resp, e_cyc, e_iss, e_lat);
    do_txn(8'h09, a, d, 0);
    chk++; if (o_cmd_t1 !== 8'h00) $display("FAIL illegal_cmd_idle: got %h exp 00", o_cmd_t1); else pass++;
    chk++; if (o_iss !== e_iss) $display("FAIL illegal_issues: got %0d exp %0d", o_iss, e_iss); else pass++;
    chk++; if (got_resp() !== e_resp) $display("FAIL illegal_resp: got %h exp %h", got_resp(), e_resp); else pass++;
    chk++; if (o_lat !== e_lat) $display("FAIL illegal_tx_latency: got %0d exp %0d", o_lat, e_lat); else pass++;
    chk++; if ({o_addr_end, o_data_end} !== {a, d})
      $display("FAIL illegal_latched_fields: got %h/%h exp %h/%h", o_addr_end, o_data_end, a, d); else pass++;
    model(8'h00, 32'h0, 1, 1, 1'b0, e_resp, e_cyc, e_iss, e_lat);
    do_txn(8'h00, $urandom, $urandom, 2);
    chk++; if (got_resp() !== e_resp) $display("FAIL nop_resp: got %h exp %h", got_resp(), e_resp); else pass++;
    chk++; if (o_iss !== e_iss) $display("FAIL nop_issues: got %0d exp %0d", o_iss, e_iss); else pass++;
    chk++; if (o_lat !== e_lat) $display("FAIL nop_tx_latency: got %0d exp %0d", o_lat, e_lat); else pass++;
  endtask

  task automatic test_timeout();
    set_stub(1, 1, 1'b1, 32'hCAFEF00D);
    model(8'h06, 32'hCAFEF00D, 1, 1, 1'b1, e_resp, e_cyc, e_iss, e_lat);
    do_txn(8'h06, 32'h100, 32'h200, 0);
    chk++; if (o_cyc !== e_cyc) $display("FAIL timeout_cmd_cycles: got %0d exp %0d", o_cyc, e_cyc); else pass++;
    chk++; if (got_resp() !== e_resp) $display("FAIL timeout_resp: got %h exp %h", got_resp(), e_resp); else pass++;
    chk++; if (o_lat !== e_lat) $display("FAIL timeout_tx_latency: got %0d exp %0d", o_lat, e_lat); else pass++;
    // done arriving in the very last counted cycle must still win
    set_stub(TMO - 1, 1, 1'b0, 32'h13572468);
    model(8'h06, 32'h13572468, TMO - 1, 1, 1'b0, e_resp, e_cyc, e_iss, e_lat);
    do_txn(8'h06, 32'h300, 32'h400, 0);
    chk++; if (o_cyc !== e_cyc) $display("FAIL edge_done_cmd_cycles: got %0d exp %0d", o_cyc, e_cyc); else pass++;
    chk++; if (got_resp() !== e_resp) $display("FAIL edge_done_resp: got %h exp %h", got_resp(), e_resp); else pass++;
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] rd, a, d;
    int n;
    rd = $urandom; a = $urandom; d = $urandom;
    set_stub(2, 1, 1'b0, rd);
    model(8'h05, rd, 2, 1, 1'b0, e_resp, e_cyc, e_iss, e_lat);
    do_txn(8'h05, a, d, 1);
    chk++; if (got_resp() !== e_resp) $display("FAIL toggle_resp: got %h exp %h", got_resp(), e_resp); else pass++;
    chk++; if (o_stable !== 1'b1) $display("FAIL toggle_hold_stable: got %b exp 1", o_stable); else pass++;
    // reset during EXEC
    set_stub(1, 1, 1'b1, 32'h0);
    send_byte(8'h06);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    @(negedge clk);
    rx_valid = 1'b0;
    n = 0;
    while (bus.cmd === 8'h00 && n < 50) begin @(negedge clk); n++; end
    chk++; if (bus.cmd !== 8'h06) $display("FAIL reset_exec_entered: got %h exp 06", bus.cmd); else pass++;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk++; if (bus.cmd !== 8'h00) $display("FAIL midreset_cmd: got %h exp 00", bus.cmd); else pass++;
    chk++; if ({rx_ready, tx_valid} !== 2'b10)
      $display("FAIL midreset_handshake: got rdy=%b vld=%b exp rdy=1 vld=0", rx_ready, tx_valid); else pass++;
    chk++; if (bus.addr !== 32'h0) $display("FAIL midreset_addr: got %h exp 0", bus.addr); else pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    // partial packet discarded by reset
    for (int i = 0; i < 4; i++) send_byte(8'h03);
    @(negedge clk);
    rx_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    rd = $urandom; a = $urandom; d = $urandom;
    set_stub(1, 1, 1'b0, rd);
    model(8'h02, rd, 1, 1, 1'b0, e_resp, e_cyc, e_iss, e_lat);
    do_txn(8'h02, a, d, 2);
    chk++; if (got_resp() !== e_resp) $display("FAIL post_reset_resp: got %h exp %h", got_resp(), e_resp); else pass++;
    chk++; if (mon_addr !== a) $display("FAIL post_reset_addr: got %h exp %h", mon_addr, a); else pass++;
    chk++; if (o_iss !== e_iss) $display("FAIL post_reset_issues: got %0d exp %0d", o_iss, e_iss); else pass++;
  endtask

  task automatic test_back_to_back_random();
    logic [7:0]  c;
    logic [31:0] a, d, rd;
    int          dly, hld, mode, sel;
    bit          never;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      c = 8'h00;
      else if (sel == 1) c = 8'($urandom_range(7, 255));
      else               c = 8'($urandom_range(1, 6));
      a = $urandom; d = $urandom; rd = $urandom;
      dly = $urandom_range(1, TMO - 1);
      hld = $urandom_range(1, 3);
      never = ($urandom_range(0, 9) == 0);
      mode = $urandom_range(0, 2);
      set_stub(dly, hld, never, rd);
      model(c, rd, dly, hld, never, e_resp, e_cyc, e_iss, e_lat);
      do_txn(c, a, d, mode);
      chk++; if (got_resp() !== e_resp)
        $display("FAIL rand%0d_resp: cmd=%h got %h exp %h", it, c, got_resp(), e_resp); else pass++;
      chk++; if (o_cyc !== e_cyc)
        $display("FAIL rand%0d_cmd_cycles: cmd=%h got %0d exp %0d", it, c, o_cyc, e_cyc); else pass++;
      chk++; if (o_iss !== e_iss)
        $display("FAIL rand%0d_issues: cmd=%h got %0d exp %0d", it, c, o_iss, e_iss); else pass++;
      chk++; if (o_lat !== e_lat)
        $display("FAIL rand%0d_tx_latency: cmd=%h got %0d exp %0d", it, c, o_lat, e_lat); else pass++;
      chk++; if (o_stable !== 1'b1) $display("FAIL rand%0d_hold_stable: got %b exp 1", it, o_stable); else pass++;
      chk++; if ({o_addr_end, o_data_end} !== {a, d})
        $display("FAIL rand%0d_latched_fields: got %h/%h exp %h/%h", it, o_addr_end, o_data_end, a, d); else pass++;
      chk++; if ({o_rdy_after, o_vld_after} !== 2'b10)
        $display("FAIL rand%0d_ready_after_tx: got rdy=%b vld=%b exp rdy=1 vld=0", it, o_rdy_after, o_vld_after);
      else pass++;
      if (e_iss == 1) begin
        chk++; if ({mon_cmd, mon_addr, mon_data} !== {c, a, d})
          $display("FAIL rand%0d_bus_fields: got %h/%h/%h exp %h/%h/%h", it, mon_cmd, mon_addr, mon_data, c, a, d);
        else pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_read();
    test_write();
    test_illegal_nop();
    test_timeout();
    test_backpressure_reset();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
